reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources: req0 (ALU result) and
//  req1 (load data from memory). Each source uses a valid/ready handshake. The winning request is
//  registered and presented as i_fWE/i_Rd/i_Data-compatible outputs one cycle later. A starvation
//  counter guarantees that req1 is eventually granted. Sits between the execute/memory stages and Registers.
// PARAMETERS
//  DATA_W     32  writeback data width
//  ADDR_W     5   register index width (32 registers)
//  STARVE_LIM 3   consecutive cycles req1 may lose before it is forced to win (legal range 1..15)
// PORTS
//  i_Clk        in   1       clock, all state updates on rising edge
//  i_Rst        in   1       asynchronous, active-low reset
//  i_Valid0     in   1       req0 (ALU) has a writeback
//  i_Rd0        in   ADDR_W  req0 destination register
//  i_Data0      in   DATA_W  req0 data
//  o_Ready0     out  1       req0 accepted this cycle (combinational)
//  i_Valid1     in   1       req1 (load) has a writeback
//  i_Rd1        in   ADDR_W  req1 destination register
//  i_Data1      in   DATA_W  req1 data
//  o_Ready1     out  1       req1 accepted this cycle (combinational)
//  o_fWE        out  1       write enable to the register file (registered)
//  o_Rd         out  ADDR_W  write index (registered)
//  o_Data       out  DATA_W  write data (registered)
//  o_Starved    out  1       high while the forced-req1 state is active (debug/perf)
// BEHAVIOUR
//  - Reset (i_Rst=0, async): o_fWE=0, o_Rd=0, o_Data=0, o_Starved=0, r_Wait=0, state=NORMAL.
//    o_Ready0/1 are 0 throughout reset.
//  - Handshake: a transfer occurs when valid&&ready in the same cycle. A source holds valid, Rd and Data
//    stable until it is accepted. At most one ready is high per cycle. Ready is never high without valid.
//  - Write port never stalls. Every accepted request appears on o_fWE/o_Rd/o_Data exactly 1 cycle later.
//    Throughput is 1 write/cycle.
//  - Rd==0: the request is accepted (ready=1) but is dropped. o_fWE=0 on the next cycle, o_Rd/o_Data still update.
//  - FSM states:
//    NORMAL: if valid0, grant req0. Else if valid1, grant req1.
//    FORCE1: if valid1, grant req1. Else (not reachable, see below) grant req0 if valid0.
//  - Wait counter r_Wait (4 bits):
//    . increments each cycle where valid1 && !ready1;
//    . clears on any req1 grant, and whenever valid1==0.
//  - Transitions:
//    . NORMAL->FORCE1 when r_Wait reaches STARVE_LIM at the clock edge. The forced grant takes effect the cycle after.
//    . FORCE1->NORMAL after the req1 grant.
//    . FORCE1 is only entered with valid1 high. Because valid1 is held, FORCE1 lasts exactly 1 cycle.
//  - o_Starved = (state==FORCE1).
//  - Simultaneous same Rd on both sources: the loser is simply delayed. Writes land in grant order, and the
//    register file sees the later grant last. Ordering correctness is the pipeline's responsibility.
//  - No valid on either source: o_fWE=0 next cycle, o_Rd/o_Data hold their previous values.
//  - Reset asserted mid-operation: outputs clear immediately, and a pending registered write is lost.
//    Sources must re-present their requests after reset.
//  - Width: no arithmetic on data. r_Wait saturates at 15.
// STRUCTURE
//  - Shared package: REG_ADDR_W=5, XLEN=32, and the state encoding (NORMAL=1'b0, FORCE1=1'b1).
//    Registers and decode use the same constants.
//  - Single module. The grant/FSM logic is small enough to stay inline, so no sub-module is needed.
// TESTING
//  1. Reset: hold i_Rst=0 with both valids high -> o_fWE=0, o_Rd=0, o_Data=0, o_Ready0=o_Ready1=0.
//  2. Single req0, Rd=5, Data=0xDEADBEEF -> o_Ready0=1 in cycle N. In cycle N+1: o_fWE=1, o_Rd=5, o_Data=0xDEADBEEF.
//  3. Rd=0 from req1, Data=0x1234 -> o_Ready1=1. Next cycle o_fWE=0.
//  4. Contention: req0 valid every cycle (Rd=1..), req1 valid with Rd=7 and STARVE_LIM=3.
//     -> req1 loses 3 cycles, o_Starved=1 in the 4th cycle with o_Ready1=1 and o_Ready0=0.
//     -> Next cycle o_Rd=7, then req0 resumes.
//  5. Back-to-back alternation: req0 and req1 valid only on alternate cycles -> o_fWE=1 every cycle, r_Wait stays 0.
//  6. Async reset mid-stream: assert i_Rst=0 between clock edges while o_fWE=1 -> o_fWE drops immediately.
//     After release, the first accepted request appears 1 cycle later.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter_pkg
//   Constants shared by the register file, decode and the writeback arbiter,
//   plus the arbiter's state encoding.
//   REG_ADDR_W : register index width (32 registers)
//   XLEN       : register / writeback data width
//   WAIT_W     : width of the req1 starvation counter
//   arb_state_e: NORMAL (req0 has priority), FORCE1 (req1 is forced to win)
// ---------------------------------------------------------------------------
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int WAIT_W     = 4;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter_if
//   Writeback bus between the execute/memory stages, the arbiter and the
//   register file write port.
//   i_Valid0/i_Rd0/i_Data0/o_Ready0 : req0 (ALU result) handshake
//   i_Valid1/i_Rd1/i_Data1/o_Ready1 : req1 (load data) handshake
//   o_fWE/o_Rd/o_Data               : registered register-file write port
//   o_Starved                       : high while req1 is being forced through
//   Modports: slave = the arbiter, master = the sources / consumer side.
// ---------------------------------------------------------------------------
interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
);
    logic              i_Valid0;
    logic [ADDR_W-1:0] i_Rd0;
    logic [DATA_W-1:0] i_Data0;
    logic              o_Ready0;

    logic              i_Valid1;
    logic [ADDR_W-1:0] i_Rd1;
    logic [DATA_W-1:0] i_Data1;
    logic              o_Ready1;

    logic              o_fWE;
    logic [ADDR_W-1:0] o_Rd;
    logic [DATA_W-1:0] o_Data;
    logic              o_Starved;

    modport slave (
        input  i_Valid0, i_Rd0, i_Data0,
        input  i_Valid1, i_Rd1, i_Data1,
        output o_Ready0, o_Ready1,
        output o_fWE, o_Rd, o_Data, o_Starved
    );

    modport master (
        output i_Valid0, i_Rd0, i_Data0,
        output i_Valid1, i_Rd1, i_Data1,
        input  o_Ready0, o_Ready1,
        input  o_fWE, o_Rd, o_Data, o_Starved
    );

endinterface

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//   Shares the register file's single write port between req0 (ALU) and
//   req1 (load). The winner is registered and driven onto o_fWE/o_Rd/o_Data
//   one cycle after acceptance. A saturating wait counter forces req1 to win
//   once it has lost STARVE_LIM consecutive cycles.
//   Ports:
//     i_Clk  : clock, rising edge
//     i_Rst  : asynchronous active-low reset
//     bus    : reg_wb_arbiter_if.slave (both request handshakes, write port,
//              o_Starved which mirrors the FSM state for debug)
//
//   Handshake: a transfer happens in a cycle where valid && ready. A source
//   keeps valid/Rd/Data stable until accepted. Ready is combinational, is
//   never high without its valid, at most one ready is high per cycle, and
//   both readies are low while reset is asserted.
// ---------------------------------------------------------------------------
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int STARVE_LIM = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    reg_wb_arbiter_if.slave        bus
);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] r_Wait, wait_d;
    logic              ready0, ready1;

    logic              fwe_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;

    // Grant, wait-counter and next-state logic.
    always_comb begin
        ready0  = 1'b0;
        ready1  = 1'b0;
        state_d = state_q;
        wait_d  = r_Wait;

        if (i_Rst) begin
            unique case (state_q)
                NORMAL: begin
                    if (bus.i_Valid0)      ready0 = 1'b1;
                    else if (bus.i_Valid1) ready1 = 1'b1;
                end
                FORCE1: begin
                    if (bus.i_Valid1)      ready1 = 1'b1;
                    else if (bus.i_Valid0) ready0 = 1'b1;
                end
                default: ;
            endcase
        end

        // Counts only cycles where req1 is waiting and losing; saturates.
        if (!bus.i_Valid1 || ready1)
            wait_d = '0;
        else if (r_Wait != WAIT_MAX)
            wait_d = r_Wait + 1'b1;

        unique case (state_q)
            // The forced grant lands in the cycle right after the counter
            // reaches the limit, so compare against the next counter value.
            NORMAL:  if (wait_d >= WAIT_W'(STARVE_LIM)) state_d = FORCE1;
            // req1 is held valid, so the forced state always grants it and
            // lasts one cycle; leaving unconditionally also avoids sticking
            // if a source ever drops valid illegally.
            FORCE1:  state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= NORMAL;
            r_Wait  <= '0;
        end else begin
            state_q <= state_d;
            r_Wait  <= wait_d;
        end
    end

    // Write port register. Rd==0 is accepted but never written; Rd/Data
    // still follow the accepted request. With no grant, Rd/Data hold.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            fwe_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (ready0) begin
            fwe_q  <= (bus.i_Rd0 != '0);
            rd_q   <= bus.i_Rd0;
            data_q <= bus.i_Data0;
        end else if (ready1) begin
            fwe_q  <= (bus.i_Rd1 != '0);
            rd_q   <= bus.i_Rd1;
            data_q <= bus.i_Data1;
        end else begin
            fwe_q  <= 1'b0;
        end
    end

    assign bus.o_Ready0  = ready0;
    assign bus.o_Ready1  = ready1;
    assign bus.o_fWE     = fwe_q;
    assign bus.o_Rd      = rd_q;
    assign bus.o_Data    = data_q;
    assign bus.o_Starved = (state_q == FORCE1);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_arbiter
//   Directed bench for reg_wb_arbiter (STARVE_LIM = 3). Each vector is driven
//   at a falling edge and checked 1 time unit later: the readies and
//   o_Starved describe the current cycle, o_fWE/o_Rd/o_Data show the request
//   accepted in the previous vector.
// ---------------------------------------------------------------------------
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    reg_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb_if ();

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(3)) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (wb_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
        wb_if.i_Valid0 = v0;
        wb_if.i_Rd0    = rd0;
        wb_if.i_Data0  = d0;
        wb_if.i_Valid1 = v1;
        wb_if.i_Rd1    = rd1;
        wb_if.i_Data1  = d1;
    endtask

    typedef struct {
        logic          v0;
        logic [AW-1:0] rd0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] rd1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          st;
        logic          fwe;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } vec_t;

    localparam int NV = 19;
    vec_t vec[NV];

    initial begin
        // v0 rd0 d0 | v1 rd1 d1 | r0 r1 st | fwe rd data (from previous vector)
        vec[0]  = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  0, 0,  0};
        vec[1]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,      1, 0, 0,  0, 0,  0};
        vec[2]  = '{0, 0,  0,            1, 0,  32'h1234, 0, 1, 0, 1, 5, 32'hDEADBEEF};
        vec[3]  = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  0, 0,  32'h1234};
        vec[4]  = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  0, 0,  32'h1234};
        // contention: req1 (Rd 7) loses three times, then is forced through
        vec[5]  = '{1, 1,  32'h101,      1, 7,  32'h77, 1, 0, 0,  0, 0,  32'h1234};
        vec[6]  = '{1, 2,  32'h102,      1, 7,  32'h77, 1, 0, 0,  1, 1,  32'h101};
        vec[7]  = '{1, 3,  32'h103,      1, 7,  32'h77, 1, 0, 0,  1, 2,  32'h102};
        vec[8]  = '{1, 4,  32'h104,      1, 7,  32'h77, 0, 1, 1,  1, 3,  32'h103};
        vec[9]  = '{1, 4,  32'h104,      0, 0,  0,      1, 0, 0,  1, 7,  32'h77};
        vec[10] = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  1, 4,  32'h104};
        // alternation: one write per cycle, never starved
        vec[11] = '{1, 10, 32'hA0,       0, 0,  0,      1, 0, 0,  0, 4,  32'h104};
        vec[12] = '{0, 0,  0,            1, 11, 32'hB1, 0, 1, 0,  1, 10, 32'hA0};
        vec[13] = '{1, 12, 32'hC2,       0, 0,  0,      1, 0, 0,  1, 11, 32'hB1};
        vec[14] = '{0, 0,  0,            1, 13, 32'hD3, 0, 1, 0,  1, 12, 32'hC2};
        vec[15] = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  1, 13, 32'hD3};
        // same Rd on both sources: req0 first, req1 lands last
        vec[16] = '{1, 9,  32'h900,      1, 9,  32'h901, 1, 0, 0, 0, 13, 32'hD3};
        vec[17] = '{0, 0,  0,            1, 9,  32'h901, 0, 1, 0, 1, 9,  32'h900};
        vec[18] = '{0, 0,  0,            0, 0,  0,      0, 0, 0,  1, 9,  32'h901};

        // Reset held with both sources requesting.
        drive(1, 3, 32'hAAAA, 1, 4, 32'hBBBB);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready0", 32'(wb_if.o_Ready0), 0);
        check("rst_ready1", 32'(wb_if.o_Ready1), 0);
        check("rst_fwe",    32'(wb_if.o_fWE), 0);
        check("rst_rd",     32'(wb_if.o_Rd), 0);
        check("rst_data",   wb_if.o_Data, 0);
        check("rst_starved", 32'(wb_if.o_Starved), 0);
        drive(0, 0, 0, 0, 0, 0);
        #1 rst_non_release();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].v0, vec[i].rd0, vec[i].d0, vec[i].v1, vec[i].rd1, vec[i].d1);
            #1;
            check($sformatf("v%0d_ready0", i), 32'(wb_if.o_Ready0), 32'(vec[i].r0));
            check($sformatf("v%0d_ready1", i), 32'(wb_if.o_Ready1), 32'(vec[i].r1));
            check($sformatf("v%0d_starved", i), 32'(wb_if.o_Starved), 32'(vec[i].st));
            check($sformatf("v%0d_fwe", i), 32'(wb_if.o_fWE), 32'(vec[i].fwe));
            check($sformatf("v%0d_rd", i), 32'(wb_if.o_Rd), 32'(vec[i].rd));
            check($sformatf("v%0d_data", i), wb_if.o_Data, vec[i].data);
        end

        // Async reset mid-stream: a registered write is on the port when
        // reset hits between edges; it must vanish immediately.
        @(negedge clk);
        drive(1, 20, 32'h55, 0, 0, 0);
        @(posedge clk);
        #1;
        check("mid_fwe_before", 32'(wb_if.o_fWE), 1);
        check("mid_rd_before",  32'(wb_if.o_Rd), 20);
        #2 rst_n = 1'b0;
        #1;
        check("mid_fwe_async",  32'(wb_if.o_fWE), 0);
        check("mid_rd_async",   32'(wb_if.o_Rd), 0);
        check("mid_data_async", wb_if.o_Data, 0);
        check("mid_ready0_rst", 32'(wb_if.o_Ready0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 21, 32'h66, 0, 0, 0);
        #1;
        check("post_ready0", 32'(wb_if.o_Ready0), 1);
        check("post_fwe_0",  32'(wb_if.o_fWE), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("post_fwe_1",  32'(wb_if.o_fWE), 1);
        check("post_rd_1",   32'(wb_if.o_Rd), 21);
        check("post_data_1", wb_if.o_Data, 32'h66);
        @(negedge clk);
        #1;
        check("post_fwe_2",  32'(wb_if.o_fWE), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic rst_non_release();
        rst_n = 1'b1;
    endtask

endmodule
